// File: rtl/anppv_mem_arb_pkg.sv
// Shared types and constants for the three-way memory port arbiter.
package anppv_mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_RD   = 2'd2,
        OWN_WR   = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner select: WR > RD > IF, unless fetch has starved long enough to win outright.
module mem_arb_priority
    import anppv_mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   rd_req,
    input  logic   wr_req,
    input  logic   starve_sat,
    output owner_t winner
);

    always_comb begin
        winner = OWN_NONE;
        if (if_req && starve_sat) begin
            winner = OWN_IF;
        end else if (wr_req) begin
            winner = OWN_WR;
        end else if (rd_req) begin
            winner = OWN_RD;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data read and data write with fixed wait-state access.
// Optional MEM_ARB_STATS_EN adds a saturating conflict_cnt output of contended IDLE cycles.
module mem_port_arbiter
    import anppv_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic [DATA_W-1:0] rdata,
    output logic              stall_pipe,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] conflict_cnt
`endif
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

    arb_state_t        state_reg;
    owner_t            owner_reg;
    owner_t            winner;
    logic [CNT_W-1:0]  cnt_reg;
    logic [STV_W-1:0]  starve_reg;
    logic              if_done_reg;
    logic              rd_done_reg;
    logic              wr_done_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] winner_addr;
    logic              any_req;
    logic              starve_sat;

    assign any_req    = if_req | rd_req | wr_req;
    assign starve_sat = (starve_reg == STV_SAT);

    mem_arb_priority u_priority (
        .if_req     (if_req),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .starve_sat (starve_sat),
        .winner     (winner)
    );

    always_comb begin
        winner_addr = if_addr;
        case (winner)
            OWN_WR:  winner_addr = wr_addr;
            OWN_RD:  winner_addr = rd_addr;
            default: winner_addr = if_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWN_NONE;
            cnt_reg       <= '0;
            starve_reg    <= '0;
            if_done_reg   <= 1'b0;
            rd_done_reg   <= 1'b0;
            wr_done_reg   <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rdata_reg     <= '0;
        end else begin
            if_done_reg <= 1'b0;
            rd_done_reg <= 1'b0;
            wr_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_reg    <= winner;
                        mem_addr_reg <= winner_addr;
                        if (winner == OWN_WR) begin
                            mem_wdata_reg <= wr_data;
                        end
                        mem_en_reg <= 1'b1;
                        mem_we_reg <= (winner == OWN_WR);
                        cnt_reg    <= '0;
                        state_reg  <= ST_ACCESS;
                        // Only a fetch that actually lost counts toward starvation.
                        if (winner == OWN_IF) begin
                            starve_reg <= '0;
                        end else if (if_req && !starve_sat) begin
                            starve_reg <= starve_reg + 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg == CNT_LAST) begin
                        if (owner_reg == OWN_IF || owner_reg == OWN_RD) begin
                            rdata_reg <= mem_rdata;
                        end
                        case (owner_reg)
                            OWN_IF:  if_done_reg <= 1'b1;
                            OWN_RD:  rd_done_reg <= 1'b1;
                            OWN_WR:  wr_done_reg <= 1'b1;
                            default: ;
                        endcase
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        state_reg  <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    owner_reg <= OWN_NONE;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STATS_W-1:0] conflict_reg;
    logic               contended;

    assign contended = (if_req & rd_req) | (if_req & wr_req) | (rd_req & wr_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_reg <= '0;
        end else if (state_reg == ST_IDLE && contended && conflict_reg != '1) begin
            conflict_reg <= conflict_reg + 1'b1;
        end
    end

    assign conflict_cnt = conflict_reg;
`endif

    assign if_done    = if_done_reg;
    assign rd_done    = rd_done_reg;
    assign wr_done    = wr_done_reg;
    assign mem_en     = mem_en_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign rdata      = rdata_reg;
    assign stall_pipe = (rd_req | wr_req) & ~(rd_done_reg | wr_done_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT_CYCLES=1 and =3 instances).
// With MEM_ARB_STATS_EN defined the conflict_cnt port is also exercised.
module tb_mem_port_arbiter;
    import anppv_mem_arb_pkg::*;

    logic       clk;
    logic       rst;

    // Instance A: WAIT_CYCLES=1, STARVE_MAX=4
    logic       if_req, rd_req, wr_req;
    logic [7:0] if_addr, rd_addr, wr_addr, wr_data;
    logic       if_done, rd_done, wr_done, stall_pipe, mem_en, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    // Instance B: WAIT_CYCLES=3, read-only use
    logic       b_if_req, b_rd_req, b_wr_req;
    logic [7:0] b_if_addr, b_rd_addr, b_wr_addr, b_wr_data;
    logic       b_if_done, b_rd_done, b_wr_done, b_stall_pipe, b_mem_en, b_mem_we;
    logic [7:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt, b_conflict_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .rdata(rdata), .stall_pipe(stall_pipe),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done),
        .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_done(b_rd_done),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_done(b_wr_done),
        .rdata(b_rdata), .stall_pipe(b_stall_pipe),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt(b_conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed preload pattern until a location is written by instance A.
    logic [7:0] tb_mem  [256];
    logic       tb_wflag[256];

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'hFF:   return 8'h5A;
            8'h40:   return 8'h77;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) tb_wflag[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr]   <= mem_wdata;
            tb_wflag[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata   = tb_wflag[mem_addr]   ? tb_mem[mem_addr]   : init_val(mem_addr);
    assign b_mem_rdata = tb_wflag[b_mem_addr] ? tb_mem[b_mem_addr] : init_val(b_mem_addr);

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({if_done, rd_done, wr_done, mem_en, mem_we} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {if_done, rd_done, wr_done, mem_en, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rdata} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h required 000000", {mem_addr, mem_wdata, rdata});
        end
        n_checks++;
        if ({b_mem_en, b_rd_done, b_rdata} !== 10'h0) begin
            n_errors++;
            $display("FAIL reset_b: got %h required 000", {b_mem_en, b_rd_done, b_rdata});
        end
        rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_single_fetch;
        if_addr = 8'h10;
        if_req  = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, if_done} !== {1'b1, 1'b0, 8'h10, 1'b0}) begin
            n_errors++;
            $display("FAIL fetch_access: en/we/addr/done got %b/%b/%h/%b required 1/0/10/0", mem_en, mem_we, mem_addr, if_done);
        end
        n_checks++;
        if (stall_pipe !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_stall: got %b required 0", stall_pipe);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({if_done, mem_en, rdata} !== {1'b1, 1'b0, 8'hA5}) begin
            n_errors++;
            $display("FAIL fetch_done: done/en/rdata got %b/%b/%h required 1/0/a5", if_done, mem_en, rdata);
        end
        if_req = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({if_done, mem_en, rdata} !== {1'b0, 1'b0, 8'hA5}) begin
            n_errors++;
            $display("FAIL fetch_after: done/en/rdata got %b/%b/%h required 0/0/a5", if_done, mem_en, rdata);
        end
        $display("single_fetch: addr=10 rdata=%h", rdata);
    endtask

    task automatic test_priority_order;
        int seen = 0;
        int order[3];
        if_addr = 8'h20; rd_addr = 8'h20; wr_addr = 8'h20; wr_data = 8'h3C;
        if_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        for (int cyc = 0; cyc < 30 && seen < 3; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (wr_done) begin
                order[seen] = 3; seen++;
                n_checks++;
                if (stall_pipe !== 1'b0) begin
                    n_errors++;
                    $display("FAIL order_stall_wr_done: got %b required 0", stall_pipe);
                end
                wr_req = 1'b0;
            end else if (rd_done) begin
                order[seen] = 2; seen++;
                n_checks++;
                if ({rdata, stall_pipe} !== {8'h3C, 1'b0}) begin
                    n_errors++;
                    $display("FAIL order_rd_data: rdata/stall got %h/%b required 3c/0", rdata, stall_pipe);
                end
                rd_req = 1'b0;
            end else if (if_done) begin
                order[seen] = 1; seen++;
                n_checks++;
                if (rdata !== 8'h3C) begin
                    n_errors++;
                    $display("FAIL order_if_data: got %h required 3c", rdata);
                end
                if_req = 1'b0;
            end else begin
                // Stall must track whether a data-side request is still pending.
                n_checks++;
                if (stall_pipe !== (seen < 2)) begin
                    n_errors++;
                    $display("FAIL order_stall: seen=%0d got %b required %b", seen, stall_pipe, seen < 2);
                end
            end
        end
        n_checks++;
        if (seen != 3 || order[0] != 3 || order[1] != 2 || order[2] != 1) begin
            n_errors++;
            $display("FAIL order_seq: got %0d dones order %0d,%0d,%0d required 3 dones order 3,2,1",
                     seen, order[0], order[1], order[2]);
        end
        if_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        $display("priority_order: completed %0d accesses", seen);
    endtask

    task automatic test_starvation;
        int exp_own[10] = '{3, 3, 3, 3, 1, 3, 3, 3, 3, 1};
        int seen = 0;
        int got;
        if_addr = 8'h31; wr_addr = 8'h30; wr_data = 8'h55;
        if_req = 1'b1; wr_req = 1'b1;
        for (int cyc = 0; cyc < 100 && seen < 10; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (wr_done || if_done || rd_done) begin
                got = wr_done ? 3 : (if_done ? 1 : 2);
                n_checks++;
                if (got != exp_own[seen]) begin
                    n_errors++;
                    $display("FAIL starve_grant%0d: owner got %0d required %0d", seen, got, exp_own[seen]);
                end else begin
                    $display("starvation: access %0d owner=%0d", seen, got);
                end
                seen++;
                if (seen == 10) begin
                    if_req = 1'b0; wr_req = 1'b0;
                end
            end
        end
        n_checks++;
        if (seen != 10) begin
            n_errors++;
            $display("FAIL starve_timeout: got %0d accesses required 10", seen);
        end
        if_req = 1'b0; wr_req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_wait3_read;
        b_rd_addr = 8'hFF;
        b_rd_req  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({b_mem_en, b_mem_we, b_mem_addr, b_rd_done, b_stall_pipe} !== {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL wait3_access%0d: en/we/addr/done/stall got %b/%b/%h/%b/%b required 1/0/ff/0/1",
                         k, b_mem_en, b_mem_we, b_mem_addr, b_rd_done, b_stall_pipe);
            end
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({b_rd_done, b_mem_en, b_rdata} !== {1'b1, 1'b0, 8'h5A}) begin
            n_errors++;
            $display("FAIL wait3_done: done/en/rdata got %b/%b/%h required 1/0/5a", b_rd_done, b_mem_en, b_rdata);
        end
        b_rd_req = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (b_rd_done !== 1'b0) begin
            n_errors++;
            $display("FAIL wait3_pulse: got %b required 0", b_rd_done);
        end
        $display("wait3_read: addr=ff rdata=%h", b_rdata);
    endtask

    task automatic test_reset_abort;
        b_rd_addr = 8'h40;
        b_rd_req  = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (b_mem_en !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_in_access: mem_en got %b required 1", b_mem_en);
        end
        rst = 1'b1; b_rd_req = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({b_mem_en, b_rd_done, b_rdata} !== {1'b0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL abort_reset: en/done/rdata got %b/%b/%h required 0/0/00", b_mem_en, b_rd_done, b_rdata);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({b_mem_en, b_rd_done} !== 2'b00) begin
                n_errors++;
                $display("FAIL abort_quiet%0d: en/done got %b/%b required 0/0", k, b_mem_en, b_rd_done);
            end
        end
        b_rd_addr = 8'hFF;
        b_rd_req  = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        n_checks++;
        if ({b_mem_en, b_rd_done} !== 2'b10) begin
            n_errors++;
            $display("FAIL abort_resume_access: en/done got %b/%b required 1/0", b_mem_en, b_rd_done);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({b_rd_done, b_rdata} !== {1'b1, 8'h5A}) begin
            n_errors++;
            $display("FAIL abort_resume_done: done/rdata got %b/%h required 1/5a", b_rd_done, b_rdata);
        end
        b_rd_req = 1'b0;
        @(posedge clk); @(negedge clk);
        $display("reset_abort: resumed read rdata=%h", b_rdata);
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic drain_requests;
        int left;
        left = int'(if_req) + int'(rd_req) + int'(wr_req);
        for (int cyc = 0; cyc < 50 && left > 0; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (wr_done) begin wr_req = 1'b0; left--; end
            if (rd_done) begin rd_req = 1'b0; left--; end
            if (if_done) begin if_req = 1'b0; left--; end
        end
        n_checks++;
        if (left != 0) begin
            n_errors++;
            $display("FAIL stats_drain: %0d requests left required 0", left);
        end
        if_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_stats;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (conflict_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL stats_reset: got %0d required 0", conflict_cnt);
        end
        if_addr = 8'h50; rd_addr = 8'h51; wr_addr = 8'h52; wr_data = 8'h11;
        if_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        drain_requests();
        rd_req = 1'b1; wr_req = 1'b1;
        drain_requests();
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (conflict_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL stats_count: got %0d required 3", conflict_cnt);
        end
        $display("stats: conflict_cnt=%0d", conflict_cnt);
    endtask
`endif

    initial begin
        rst = 1'b1;
        if_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        if_addr = 8'h0; rd_addr = 8'h0; wr_addr = 8'h0; wr_data = 8'h0;
        b_if_req = 1'b0; b_rd_req = 1'b0; b_wr_req = 1'b0;
        b_if_addr = 8'h0; b_rd_addr = 8'h0; b_wr_addr = 8'h0; b_wr_data = 8'h0;

        test_reset();
        test_single_fetch();
        test_priority_order();
        test_starvation();
        test_wait3_read();
        test_reset_abort();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
